// File: rtl/rfile_pkg.sv
// Shared definitions for the multi-port register file: clear-engine state
// encoding and default geometry.
package rfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/rfile_if.sv
// Register-file access bus: one write port, NUM_RD packed read ports and the
// bulk-clear handshake.
interface rfile_if
    import rfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2
) ();

    logic                     we;
    logic [ADDR_W-1:0]        waddr;
    logic [DATA_W-1:0]        wdata;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic                     clr_req;
    logic                     clr_busy;
    logic                     clr_done;

    modport master (
        output we, waddr, wdata, raddr, clr_req,
        input  rdata, clr_busy, clr_done
    );

    modport slave (
        input  we, waddr, wdata, raddr, clr_req,
        output rdata, clr_busy, clr_done
    );

endinterface

// File: rtl/rfile_clr_fsm.sv
// Bulk-clear sequencer: walks every register index once, then pulses done.
// Busy/done are registered alongside the state so they never glitch.
module rfile_clr_fsm
    import rfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr_req,
    output logic              o_clr_busy,
    output logic              o_clr_done,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr,
    output logic              o_idle
);

    // Exit on the last index rather than the counter wrap, so a full 2**ADDR_W
    // file still terminates.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);

    clr_state_e        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_busy;
    logic              r_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_clr_req) begin
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_cnt == LAST_IDX) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_clr_busy = r_busy;
    assign o_clr_done = r_done;
    assign o_clr_we   = (r_state == CLEAR);
    assign o_clr_addr = r_cnt;
    assign o_idle     = (r_state == IDLE);

endmodule

// File: rtl/rfile_mp.sv
// Parametrised multi-read-port register file with same-cycle write bypass,
// optional hardwired zero register and a sequential bulk-clear engine.
module rfile_mp
    import rfile_pkg::*;
#(
    parameter int              DATA_W   = DATA_W_DEF,
    parameter int              ADDR_W   = ADDR_W_DEF,
    parameter int              NUM_REGS = 32,
    parameter int              NUM_RD   = 2,
    parameter bit              ZERO_REG = 1'b1,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    rfile_if.slave bus
);

    logic                     w_clrWe;
    logic                     w_idle;
    logic [ADDR_W-1:0]        w_clrAddr;
    logic                     w_userWe;
    logic [ADDR_W-1:0]        w_rdAddr;
    logic [DATA_W-1:0]        w_rdVal;
    logic                     w_rdHit;
    logic [NUM_RD*DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0]        r_mem [NUM_REGS];

    rfile_clr_fsm #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_clr_fsm (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr_req  (bus.clr_req),
        .o_clr_busy (bus.clr_busy),
        .o_clr_done (bus.clr_done),
        .o_clr_we   (w_clrWe),
        .o_clr_addr (w_clrAddr),
        .o_idle     (w_idle)
    );

    // User writes only land while idle; during a clear they are dropped.
    assign w_userWe = bus.we & w_idle;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_mem[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (!(ZERO_REG && r == 0)) begin
                    if (w_clrWe && w_clrAddr == ADDR_W'(r)) begin
                        r_mem[r] <= CLR_VAL;
                    end else if (w_userWe && bus.waddr == ADDR_W'(r)) begin
                        r_mem[r] <= bus.wdata;
                    end
                end
            end
        end
    end

    // An address with no matching register leaves w_rdHit low and reads zero.
    always_comb begin
        w_rdata  = '0;
        w_rdAddr = '0;
        w_rdVal  = '0;
        w_rdHit  = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            w_rdAddr = bus.raddr[p*ADDR_W +: ADDR_W];
            w_rdVal  = '0;
            w_rdHit  = 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_rdAddr == ADDR_W'(r)) begin
                    w_rdHit = 1'b1;
                    w_rdVal = r_mem[r];
                end
            end
            if (w_rdHit && w_userWe && bus.waddr == w_rdAddr) begin
                w_rdVal = bus.wdata;
            end
            if (ZERO_REG && w_rdAddr == '0) begin
                w_rdVal = '0;
            end
            w_rdata[p*DATA_W +: DATA_W] = w_rdVal;
        end
    end

    assign bus.rdata = w_rdata;

endmodule

// File: tb/tb_rfile_mp.sv
// Randomised bench for two register-file builds (default 32x32/2 ports and a
// 16-bit, 8-entry, 3-port variant) against an array-based reference.
module tb_rfile_mp;

    localparam int          NA    = 32;
    localparam int          NB    = 8;
    localparam logic [31:0] CLR_A = 32'h0;
    localparam logic [15:0] CLR_B = 16'hA5A5;

    logic clk = 1'b0;
    logic rstN;

    always #5 clk = ~clk;

    logic        weA, clrReqA;
    logic [4:0]  waddrA;
    logic [31:0] wdataA;
    logic [9:0]  raddrA;
    logic        weB, clrReqB;
    logic [4:0]  waddrB;
    logic [15:0] wdataB;
    logic [14:0] raddrB;

    rfile_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) busA ();
    rfile_if #(.DATA_W(16), .ADDR_W(5), .NUM_RD(3)) busB ();

    assign busA.we      = weA;
    assign busA.waddr   = waddrA;
    assign busA.wdata   = wdataA;
    assign busA.raddr   = raddrA;
    assign busA.clr_req = clrReqA;
    assign busB.we      = weB;
    assign busB.waddr   = waddrB;
    assign busB.wdata   = wdataB;
    assign busB.raddr   = raddrB;
    assign busB.clr_req = clrReqB;

    rfile_mp #(
        .DATA_W(32), .ADDR_W(5), .NUM_REGS(NA), .NUM_RD(2),
        .ZERO_REG(1'b1), .CLR_VAL(CLR_A)
    ) dutA (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .bus     (busA)
    );

    rfile_mp #(
        .DATA_W(16), .ADDR_W(5), .NUM_REGS(NB), .NUM_RD(3),
        .ZERO_REG(1'b0), .CLR_VAL(CLR_B)
    ) dutB (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .bus     (busB)
    );

    int          checkCount = 0;
    int          errorCount = 0;
    logic [31:0] modelA [NA];
    logic [15:0] modelB [NB];
    bit          idleA, idleB;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference read: zero register, range check, bypass, then stored value.
    function automatic logic [31:0] expA(input logic [4:0] a);
        if (a == 5'd0) return '0;
        if (idleA && weA && waddrA == a) return wdataA;
        return modelA[a];
    endfunction

    function automatic logic [15:0] expB(input logic [4:0] a);
        if (int'(a) >= NB) return '0;
        if (idleB && weB && waddrB == a) return wdataB;
        return modelB[a[2:0]];
    endfunction

    task automatic checkReads(input string tag);
        for (int p = 0; p < 2; p++)
            checkOutput({tag, "A"}, 64'(busA.rdata[p*32 +: 32]), 64'(expA(raddrA[p*5 +: 5])));
        for (int p = 0; p < 3; p++)
            checkOutput({tag, "B"}, 64'(busB.rdata[p*16 +: 16]), 64'(expB(raddrB[p*5 +: 5])));
    endtask

    task automatic clearModels();
        for (int r = 0; r < NA; r++) modelA[r] = '0;
        for (int r = 0; r < NB; r++) modelB[r] = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply this cycle's writes to the reference, then advance one clock.
    task automatic commit();
        if (idleA && weA && waddrA != 5'd0) modelA[waddrA] = wdataA;
        if (idleB && weB && int'(waddrB) < NB) modelB[waddrB[2:0]] = wdataB;
        step();
    endtask

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            weA    = 1'($urandom_range(0, 1));
            waddrA = 5'($urandom);
            wdataA = $urandom;
            raddrA = 10'($urandom);
            if ($urandom_range(0, 3) == 0) raddrA[4:0] = waddrA;
            weB    = 1'($urandom_range(0, 1));
            waddrB = 5'($urandom_range(0, 11));
            wdataB = 16'($urandom);
            for (int p = 0; p < 3; p++) raddrB[p*5 +: 5] = 5'($urandom_range(0, 11));
            if ($urandom_range(0, 2) == 0) raddrB[9:5] = waddrB;
            #1;
            checkReads("random");
            commit();
        end
        weA = 1'b0;
        weB = 1'b0;
    endtask

    task automatic readbackAll(input string tag);
        for (int r = 0; r < 12; r++) begin
            raddrA = {5'(r + 20), 5'(r)};
            raddrB = {5'(r), 5'(11 - r), 5'(r)};
            #1;
            checkReads(tag);
        end
    endtask

    // Runs a clear on build A; abortAfter>0 pulls reset after that many busy cycles.
    task automatic runClearA(input int abortAfter);
        int busyCycles = 0;
        int clrIdx = 0;
        weA = 1'b0;
        weB = 1'b0;
        clrReqA = 1'b1;
        step();
        clrReqA = 1'b0;
        idleA = 1'b0;
        while (busA.clr_busy === 1'b1 && busyCycles < 100) begin
            if (abortAfter > 0 && busyCycles == abortAfter) break;
            weA = 1'b1;
            waddrA = 5'd3;
            wdataA = 32'hAA;
            raddrA = {5'($urandom_range(0, 31)), 5'd3};
            #1;
            checkReads("clearRead");
            checkOutput("doneDuringClearA", 64'(busA.clr_done), 64'd0);
            if (clrIdx != 0) modelA[clrIdx] = CLR_A;
            clrIdx++;
            busyCycles++;
            step();
        end
        weA = 1'b0;
        if (abortAfter > 0) begin
            checkOutput("abortCycleA", 64'(busyCycles), 64'(abortAfter));
            rstN = 1'b0;
            #1;
            checkOutput("abortBusyFallA", 64'(busA.clr_busy), 64'd0);
            checkOutput("abortDoneA", 64'(busA.clr_done), 64'd0);
            clearModels();
            idleA = 1'b1;
            #1 rstN = 1'b1;
            for (int i = 0; i < 3; i++) begin
                step();
                checkOutput("noDoneAfterAbortA", 64'(busA.clr_done), 64'd0);
                checkOutput("noBusyAfterAbortA", 64'(busA.clr_busy), 64'd0);
            end
        end else begin
            checkOutput("busyLenA", 64'(busyCycles), 64'(NA));
            checkOutput("donePulseA", 64'(busA.clr_done), 64'd1);
            checkOutput("busyInDoneA", 64'(busA.clr_busy), 64'd0);
            step();
            idleA = 1'b1;
            checkOutput("doneOneCycleA", 64'(busA.clr_done), 64'd0);
        end
        readbackAll("afterClearA");
    endtask

    task automatic runClearB();
        int busyCycles = 0;
        int clrIdx = 0;
        weA = 1'b0;
        clrReqB = 1'b1;
        step();
        clrReqB = 1'b0;
        idleB = 1'b0;
        while (busB.clr_busy === 1'b1 && busyCycles < 100) begin
            weB = 1'b1;
            waddrB = 5'd2;
            wdataB = 16'h1234;
            raddrB = {5'd9, 5'(clrIdx), 5'd2};
            #1;
            checkReads("clearRead");
            if (clrIdx < NB) modelB[clrIdx] = CLR_B;
            clrIdx++;
            busyCycles++;
            step();
        end
        weB = 1'b0;
        checkOutput("busyLenB", 64'(busyCycles), 64'(NB));
        checkOutput("donePulseB", 64'(busB.clr_done), 64'd1);
        step();
        idleB = 1'b1;
        checkOutput("doneOneCycleB", 64'(busB.clr_done), 64'd0);
        raddrB = {5'd31, 5'd8, 5'd9};
        #1;
        checkOutput("outOfRangeB", 64'(busB.rdata[15:0]), 64'd0);
        readbackAll("afterClearB");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN = 1'b0;
        weA = 1'b0; waddrA = '0; wdataA = '0; raddrA = '0; clrReqA = 1'b0;
        weB = 1'b0; waddrB = '0; wdataB = '0; raddrB = '0; clrReqB = 1'b0;
        idleA = 1'b1;
        idleB = 1'b1;
        clearModels();
        #12 rstN = 1'b1;
        step();

        // Write r5 then reset: storage must come back as zero.
        weA = 1'b1; waddrA = 5'd5; wdataA = 32'hDEADBEEF; raddrA = {5'd5, 5'd5};
        commit();
        weA = 1'b0;
        #1;
        checkOutput("r5Written", 64'(busA.rdata[31:0]), 64'hDEADBEEF);
        rstN = 1'b0;
        #1;
        clearModels();
        checkOutput("resetR5", 64'(busA.rdata[31:0]), 64'd0);
        checkOutput("resetBusy", 64'(busA.clr_busy), 64'd0);
        checkOutput("resetDone", 64'(busA.clr_done), 64'd0);
        #1 rstN = 1'b1;

        // Same-cycle bypass to both ports, then the stored value.
        weA = 1'b1; waddrA = 5'd7; wdataA = 32'h12345678; raddrA = {5'd7, 5'd7};
        #1;
        checkOutput("bypassR7p0", 64'(busA.rdata[31:0]), 64'h12345678);
        checkOutput("bypassR7p1", 64'(busA.rdata[63:32]), 64'h12345678);
        commit();
        weA = 1'b0;
        #1;
        checkOutput("storedR7p0", 64'(busA.rdata[31:0]), 64'h12345678);
        checkOutput("storedR7p1", 64'(busA.rdata[63:32]), 64'h12345678);

        // Zero register ignores writes and never bypasses.
        weA = 1'b1; waddrA = 5'd0; wdataA = 32'hFFFFFFFF; raddrA = '0;
        #1;
        checkOutput("zeroBypassP0", 64'(busA.rdata[31:0]), 64'd0);
        checkOutput("zeroBypassP1", 64'(busA.rdata[63:32]), 64'd0);
        commit();
        weA = 1'b0;
        #1;
        checkOutput("zeroStoredP0", 64'(busA.rdata[31:0]), 64'd0);
        checkOutput("zeroStoredP1", 64'(busA.rdata[63:32]), 64'd0);

        applyStimulus(150);

        for (int r = 1; r < NA; r++) begin
            weA = 1'b1; waddrA = 5'(r); wdataA = 32'(r);
            commit();
        end
        weA = 1'b0;
        readbackAll("filled");

        runClearA(0);
        runClearB();
        applyStimulus(40);
        runClearA(10);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
